count_sched: RTL and testbench
==============================

# count_sched

Round-robin scheduler that shares one loadable W-bit up-counter between NREQ requesters. Each requester asks for a counting window of a given length; the block arbitrates, loads the counter, sequences counting under an enable, and detects terminal count. It signals completion and the winner's index. It sits in front of the shared counter datapath and owns its load, enable and terminal-count logic.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 3: counter and length width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request, level.
- len  in  NREQ*W  per-requester terminal value; slice i is len[i*W +: W].
- en  in  1  count enable; a low level holds the counter.
- gnt  out  NREQ  one-hot grant; reset 0.
- busy  out  1  high in every state except IDLE; reset 0.
- cnt_q  out  W  shared counter value; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- done_id  out  $clog2(NREQ)  index of the finished requester, valid with done; reset 0.
- aborted  out  1  qualifies done as an abort; reset 0; tied 0 unless COUNT_SCHED_ABORT_EN is defined.

## Operation

- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit at or after the priority pointer ptr, wrapping modulo NREQ.
  - Set gnt to that one-hot value, register the winner index, and go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD:
  - cnt_q <= 0.
  - Latch the winner's len slice into len_r. len is sampled only here; later changes are ignored.
  - Go to COUNT.
- COUNT:
  - If cnt_q == len_r, go to DONE. en has no effect on this check.
  - Otherwise, if en is high, cnt_q <= cnt_q + 1.
  - Otherwise, hold.
- DONE:
  - done = 1 and done_id = winner.
  - ptr <= (winner + 1) mod NREQ.
  - On the next edge: gnt <= 0 and go to IDLE.
- gnt stays stable and one-hot from LOAD through DONE.
- Arithmetic is W bits. cnt_q never exceeds len_r, so it never wraps.
- len = 0: COUNT lasts one cycle, then DONE.
- len = 2^W-1: the full range is counted with no wrap.
- Without COUNT_SCHED_ABORT_EN, a requester dropping req while granted is ignored and the window runs to completion.
- Reset is asynchronous at any point, including mid-window:
  - state = IDLE and ptr = 0.
  - All outputs return to their reset values immediately.

## Timing

- Request sampled at edge E1 (state IDLE) → gnt high after E1.
- E2: LOAD completes, cnt_q = 0.
- With en held high, cnt_q reaches len after edge E2+len.
- DONE is entered at edge E3+len, so done is high during the cycle after E3+len.
- IDLE is re-entered at edge E4+len, and gnt drops at the same edge.
- Back-to-back operation: the next grant appears after E5+len. There is one IDLE arbitration cycle between windows.
- Each cycle with en low in COUNT adds exactly one cycle of latency.
- A new request arriving during LOAD, COUNT or DONE waits; it is arbitrated in the next IDLE.

## Configuration

- Macro: COUNT_SCHED_ABORT_EN.
- When defined, in LOAD or COUNT, if req[winner] is low:
  - Go to DONE on the next edge with aborted = 1.
  - done and done_id behave as normal, and ptr advances as normal.
  - cnt_q holds its value at the point of abort.
- When not defined:
  - Dropped requests are ignored.
  - aborted is constant 0.

## Test plan

- Reset mid-window:
  - Stimulus: NREQ=4, W=3. Assert reset low while cnt_q = 3.
  - Response: gnt, busy, cnt_q, done and done_id go to 0 without waiting for a clock edge. After release, the first grant goes to requester 0.
- Single request:
  - Stimulus: req=0001, len[0]=5, en=1.
  - Response: gnt=0001 after E1. cnt_q goes 0..5. done=1 with done_id=0 after E8, one cycle wide. gnt=0 after E9.
- Round-robin:
  - Stimulus: req=1111 held high, all len=0.
  - Response: done_id sequence 0,1,2,3,0. Windows are 4 cycles apart from the first done (done, IDLE, LOAD, COUNT).
- Enable stall and max length:
  - Stimulus: len=7, en toggling 1,0.
  - Response: cnt_q increments only on en=1 cycles and reaches 7 with no wrap. done arrives 7 cycles later than with en held high.
- Length sampling:
  - Stimulus: change len[winner] from 2 to 6 during COUNT.
  - Response: counting still stops at 2.
- Abort (COUNT_SCHED_ABORT_EN only):
  - Stimulus: drop req[winner] while cnt_q = 2, len = 6.
  - Response: done=1 with aborted=1 on the following cycle, cnt_q stays 2, ptr advances.
  - Without the macro, the same stimulus runs to 6 with aborted=0.

Source files
------------

// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one loadable W-bit up-counter among NREQ requesters.
// Define COUNT_SCHED_ABORT_EN to end a window early when the winner drops its request.
module count_sched #(
    parameter int NREQ = 4,
    parameter int W    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        len,
    input  logic                     en,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic [W-1:0]             cnt_q,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic                     aborted
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, win, pick;
    logic [W-1:0]  len_r;
    logic          found, abort;

    // first requester at or after ptr, wrapping
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[IW'((int'(ptr) + i) % NREQ)]) begin
                pick  = IW'((int'(ptr) + i) % NREQ);
                found = 1'b1;
            end
        end
    end

`ifdef COUNT_SCHED_ABORT_EN
    logic ab_r;
    assign abort   = (state == LOAD || state == COUNT) && !req[win];
    assign aborted = (state == DONE) && ab_r;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ab_r <= 1'b0;
        else if (state != DONE)
            ab_r <= abort;
    end
`else
    assign abort   = 1'b0;
    assign aborted = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? LOAD : IDLE;
            LOAD:    state_nx = abort ? DONE : COUNT;
            COUNT:   state_nx = (abort || cnt_q == len_r) ? DONE : COUNT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            cnt_q <= '0;
            len_r <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found)
                win <= pick;
            if (state == LOAD && !abort) begin
                cnt_q <= '0;
                len_r <= len[int'(win)*W +: W];
            end
            if (state == COUNT && !abort && cnt_q != len_r && en)
                cnt_q <= cnt_q + W'(1);
            if (state == DONE)
                ptr <= IW'((int'(win) + 1) % NREQ);
        end
    end

    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign done_id = done ? win : '0;
    assign gnt     = busy ? NREQ'(1) << win : '0;
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: directed self-checking bench for count_sched (NREQ=4, W=3).
module tb_count_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] len;
    logic        en;
    logic [3:0]  gnt;
    logic        busy;
    logic [2:0]  cnt_q;
    logic        done;
    logic [1:0]  done_id;
    logic        aborted;
    int          checks = 0;
    int          errors = 0;

`ifdef COUNT_SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    count_sched #(.NREQ(4), .W(3)) dut (
        .clk(clk), .reset(reset), .req(req), .len(len), .en(en),
        .gnt(gnt), .busy(busy), .cnt_q(cnt_q), .done(done),
        .done_id(done_id), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || cnt_q !== 3'd0 || done !== 1'b0 ||
            done_id !== 2'd0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL %s: gnt=%b busy=%b cnt_q=%0d done=%b done_id=%0d aborted=%b, required all 0",
                     name, gnt, busy, cnt_q, done, done_id, aborted);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b0;
        len   = '0;
        en    = 1'b1;
        #2;
        check_idle("reset_initial");
        step();
        reset = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0001;
        len[0 +: 3] = 3'd5;
        step();
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b busy=%b, required 0001 1", gnt, busy);
        end
        for (int k = 0; k <= 5; k++) begin
            step();
            checks++;
            if (cnt_q !== 3'(k) || done !== 1'b0) begin
                errors++;
                $display("FAIL single_count: cnt_q=%0d done=%b, required %0d 0", cnt_q, done, k);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || done_id !== 2'd0 || cnt_q !== 3'd5 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_done: done=%b done_id=%0d cnt_q=%0d gnt=%b, required 1 0 5 0001",
                     done, done_id, cnt_q, gnt);
        end
        req = 4'b0;
        step();
        checks++;
        if (done !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: done=%b gnt=%b busy=%b, required 0 0000 0", done, gnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        len[3 +: 3] = 3'd6;
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_grant: gnt=%b, required 0010", gnt);
        end
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (cnt_q !== 3'd3) begin
            errors++;
            $display("FAIL mid_cnt: cnt_q=%0d, required 3", cnt_q);
        end
        reset = 1'b0;
        #2;
        check_idle("mid_async_reset");
        req = 4'b1111;
        len = '0;
        #2;
        reset = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant: gnt=%b, required 0001", gnt);
        end
        reset = 1'b0;
        req   = 4'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ids [5];
        int         idx = 0;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = 4'b1111;
        len = '0;
        en  = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            step();
            checks++;
            if (done !== (n % 4 == 3)) begin
                errors++;
                $display("FAIL rr_done_timing: cycle %0d done=%b, required %b", n, done, n % 4 == 3);
            end
            if (n % 4 == 3) begin
                checks++;
                if (done_id !== exp_ids[idx] || gnt !== (4'b0001 << exp_ids[idx])) begin
                    errors++;
                    $display("FAIL rr_done_id: done_id=%0d gnt=%b, required %0d %b",
                             done_id, gnt, exp_ids[idx], 4'b0001 << exp_ids[idx]);
                end
                idx++;
            end
        end
        req = 4'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_stall_max();
        logic [2:0] exp_cnt = 3'd0;
        req = 4'b0010;
        len[3 +: 3] = 3'd7;
        en = 1'b1;
        step();
        step();
        for (int k = 3; k <= 16; k++) begin
            en = (k % 2 == 0);
            step();
            if (en && exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
            checks++;
            if (cnt_q !== exp_cnt || done !== 1'b0) begin
                errors++;
                $display("FAIL stall_count: edge %0d cnt_q=%0d done=%b, required %0d 0", k, cnt_q, done, exp_cnt);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (done !== 1'b1 || cnt_q !== 3'd7 || done_id !== 2'd1) begin
            errors++;
            $display("FAIL stall_done: done=%b cnt_q=%0d done_id=%0d, required 1 7 1", done, cnt_q, done_id);
        end
        req = 4'b0;
        step();
    endtask

    task automatic test_len_sample();
        req = 4'b0100;
        len[6 +: 3] = 3'd2;
        en = 1'b1;
        step();
        step();
        step();
        len[6 +: 3] = 3'd6;
        step();
        checks++;
        if (cnt_q !== 3'd2 || done !== 1'b0) begin
            errors++;
            $display("FAIL lensamp_count: cnt_q=%0d done=%b, required 2 0", cnt_q, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || cnt_q !== 3'd2 || done_id !== 2'd2) begin
            errors++;
            $display("FAIL lensamp_done: done=%b cnt_q=%0d done_id=%0d, required 1 2 2", done, cnt_q, done_id);
        end
        req = 4'b0;
        step();
    endtask

    task automatic test_abort();
        int         wait_n  = ABORT_EN ? 1 : 5;
        logic [2:0] exp_cnt = ABORT_EN ? 3'd2 : 3'd6;
        req = 4'b1000;
        len[9 +: 3] = 3'd6;
        en = 1'b1;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (cnt_q !== 3'd2) begin
            errors++;
            $display("FAIL abort_pre: cnt_q=%0d, required 2", cnt_q);
        end
        req = 4'b0;
        for (int k = 1; k < wait_n; k++) begin
            step();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_early_done: done=%b, required 0", done);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || aborted !== ABORT_EN || cnt_q !== exp_cnt || done_id !== 2'd3) begin
            errors++;
            $display("FAIL abort_done: done=%b aborted=%b cnt_q=%0d done_id=%0d, required 1 %b %0d 3",
                     done, aborted, cnt_q, done_id, ABORT_EN, exp_cnt);
        end
        req = 4'b1001;
        step();
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL abort_ptr: gnt=%b, required 0001", gnt);
        end
        req = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_stall_max();
        test_len_sample();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
